// File: rtl/lmc_tx_striper.sv
// lmc_tx_striper
// Transmit-side lane striper. Takes 64-byte words from the TX framing stage over
// a valid/ready handshake and spreads them byte-wise across the active PIPE
// lanes. When the active lanes take fewer than 64 bytes per cycle, the word is
// held in a single buffer and sent out one slice per cycle.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-low reset
//   GEN          generation 1..5 (other values behave as Gen1)
//   LANESNUMBER  active lanes 1/2/4/8/16 (other values behave as x1)
//   txData       input word, byte 0 on bits [7:0]
//   txDataK      per-byte K flags, bit b goes with byte b
//   txValid      input word valid
//   txReady      word accepted on an edge where txValid && txReady
//   laneData     lane i on [32i+31:32i], lane byte j on [32i+8j+7:32i+8j]
//   laneDataK    lane i K flags on [4i+3:4i]
//   laneValid    bit i high when lane i carries data this cycle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no word buffered, ready for a new one
// ST_SEND  | buffered word being emitted, slice idx_q goes out next edge
module lmc_tx_striper #(
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 16,
    parameter int GEN3_PIPEWIDTH = 32,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   GEN,
    input  logic [4:0]   LANESNUMBER,
    input  logic [511:0] txData,
    input  logic [63:0]  txDataK,
    input  logic         txValid,
    output logic         txReady,
    output logic [511:0] laneData,
    output logic [63:0]  laneDataK,
    output logic [15:0]  laneValid
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;

    logic [0:0]   state_q;
    logic [5:0]   idx_q;
    logic [511:0] buf_q;
    logic [63:0]  bufk_q;
    logic [2:0]   gen_q;
    logic [4:0]   lanes_q;
    logic [511:0] lane_data_q;
    logic [63:0]  lane_k_q;
    logic [15:0]  lane_valid_q;

    logic [1:0]   w_log;
    logic [2:0]   l_log;
    logic [2:0]   lw_log;
    logic [5:0]   n_m1;
    logic [15:0]  lane_mask;
    logic [511:0] slice_data_d;
    logic [63:0]  slice_k_d;
    logic         accept;

    // log2 of bytes per lane for a given PIPE width in bits
    function automatic logic [1:0] width_log(input int pw);
        case (pw)
            16:      return 2'd1;
            32:      return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Buffer byte feeding lane i, lane byte p for slice idx:
    // idx*S + p*L + i, with S and L powers of two.
    function automatic logic [5:0] src_byte(input logic [5:0] idx, input logic [2:0] lw,
                                            input logic [2:0] ll, input int p, input int i);
        int b;
        b = (int'(idx) << lw) + (p << ll) + i;
        return b[5:0];
    endfunction

    always_comb begin
        case (gen_q)
            3'd2:    w_log = width_log(GEN2_PIPEWIDTH);
            3'd3:    w_log = width_log(GEN3_PIPEWIDTH);
            3'd4:    w_log = width_log(GEN4_PIPEWIDTH);
            3'd5:    w_log = width_log(GEN5_PIPEWIDTH);
            default: w_log = width_log(GEN1_PIPEWIDTH);
        endcase
    end

    always_comb begin
        case (lanes_q)
            5'd2:    begin l_log = 3'd1; lane_mask = 16'h0003; end
            5'd4:    begin l_log = 3'd2; lane_mask = 16'h000F; end
            5'd8:    begin l_log = 3'd3; lane_mask = 16'h00FF; end
            5'd16:   begin l_log = 3'd4; lane_mask = 16'hFFFF; end
            default: begin l_log = 3'd0; lane_mask = 16'h0001; end
        endcase
    end

    assign lw_log  = {1'b0, w_log} + l_log;
    assign n_m1    = 6'((7'd64 >> lw_log) - 7'd1);
    assign txReady = (state_q == ST_EMPTY) || (idx_q == n_m1);
    assign accept  = txValid && txReady;

    always_comb begin
        slice_data_d = '0;
        slice_k_d    = '0;
        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < 4; p++) begin
                if ((i < (1 << l_log)) && (p < (1 << w_log))) begin
                    slice_data_d[32*i + 8*p +: 8] = buf_q[8*src_byte(idx_q, lw_log, l_log, p, i) +: 8];
                    slice_k_d[4*i + p]            = bufk_q[src_byte(idx_q, lw_log, l_log, p, i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            idx_q        <= '0;
            buf_q        <= '0;
            bufk_q       <= '0;
            gen_q        <= 3'd1;
            lanes_q      <= 5'd1;
            lane_data_q  <= '0;
            lane_k_q     <= '0;
            lane_valid_q <= '0;
        end else begin
            if (state_q == ST_SEND) begin
                lane_data_q  <= slice_data_d;
                lane_k_q     <= slice_k_d;
                lane_valid_q <= lane_mask;
            end else begin
                lane_data_q  <= '0;
                lane_k_q     <= '0;
                lane_valid_q <= '0;
            end

            // The last slice leaves on the same edge a reload happens, so the
            // outgoing slice still uses the old buffer and config.
            if (accept) begin
                state_q <= ST_SEND;
                idx_q   <= '0;
                buf_q   <= txData;
                bufk_q  <= txDataK;
                gen_q   <= GEN;
                lanes_q <= LANESNUMBER;
            end else if (state_q == ST_SEND) begin
                if (idx_q == n_m1) begin
                    state_q <= ST_EMPTY;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + 6'd1;
                end
            end
        end
    end

    assign laneData  = lane_data_q;
    assign laneDataK = lane_k_q;
    assign laneValid = lane_valid_q;

endmodule

// File: tb/tb_lmc_tx_striper.sv
module tb_lmc_tx_striper;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   GEN;
    logic [4:0]   LANESNUMBER;
    logic [511:0] txData;
    logic [63:0]  txDataK;
    logic         txValid;
    logic         txReady;
    logic [511:0] laneData;
    logic [63:0]  laneDataK;
    logic [15:0]  laneValid;

    lmc_tx_striper dut (
        .clk         (clk),
        .reset       (reset),
        .GEN         (GEN),
        .LANESNUMBER (LANESNUMBER),
        .txData      (txData),
        .txDataK     (txDataK),
        .txValid     (txValid),
        .txReady     (txReady),
        .laneData    (laneData),
        .laneDataK   (laneDataK),
        .laneValid   (laneValid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: word buffer plus count of slices still to emit.
    logic [7:0] m_word [64];
    logic       m_k    [64];
    int         m_rem;
    int         m_l;
    int         m_w;
    int         m_n;
    logic [511:0] exp_data;
    logic [63:0]  exp_k;
    logic [15:0]  exp_v;
    bit         last_acc;
    int         vcount;

    function automatic int dec_w(input int g);
        case (g)
            2:       return 2;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int dec_l(input int n);
        if (n == 1 || n == 2 || n == 4 || n == 8 || n == 16) return n;
        return 1;
    endfunction

    task automatic model_reset();
        m_rem = 0;
        m_l   = 1;
        m_w   = 1;
        m_n   = 64;
    endtask

    task automatic model_edge(input bit acc);
        int j;
        int s;
        exp_data = '0;
        exp_k    = '0;
        exp_v    = '0;
        if (m_rem > 0) begin
            s = m_l * m_w;
            j = m_n - m_rem;
            for (int k = 0; k < s; k++) begin
                exp_data[32*(k % m_l) + 8*(k / m_l) +: 8] = m_word[j*s + k];
                exp_k[4*(k % m_l) + (k / m_l)]            = m_k[j*s + k];
            end
            for (int l = 0; l < m_l; l++) exp_v[l] = 1'b1;
            m_rem--;
        end
        if (acc) begin
            for (int b = 0; b < 64; b++) begin
                m_word[b] = txData[8*b +: 8];
                m_k[b]    = txDataK[b];
            end
            m_l   = dec_l(int'(LANESNUMBER));
            m_w   = dec_w(int'(GEN));
            m_n   = 64 / (m_l * m_w);
            m_rem = m_n;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic run_cycle();
        bit acc;
        acc = txValid && (m_rem <= 1);
        check_eq("txReady", txReady, (m_rem <= 1));
        @(posedge clk);
        model_edge(acc);
        last_acc = acc;
        @(negedge clk);
        check_eq("laneData", laneData, exp_data);
        check_eq("laneDataK", laneDataK, exp_k);
        check_eq("laneValid", laneValid, exp_v);
        if (laneValid != 16'h0) vcount++;
    endtask

    task automatic ramp_data(input int base);
        for (int b = 0; b < 64; b++) txData[8*b +: 8] = 8'(base + b);
    endtask

    int naccept;
    int lanes_tab [10] = '{1, 2, 4, 8, 16, 3, 0, 5, 31, 16};

    initial begin
        reset       = 1'b0;
        txValid     = 1'b0;
        GEN         = 3'd1;
        LANESNUMBER = 5'd1;
        txData      = '0;
        txDataK     = '0;
        vcount      = 0;
        last_acc    = 1'b0;
        model_reset();
        #12;
        check_eq("rst_ready", txReady, 1'b1);
        check_eq("rst_valid", laneValid, 16'h0);
        check_eq("rst_data", laneData, '0);
        check_eq("rst_k", laneDataK, '0);
        @(negedge clk);
        reset = 1'b1;

        // x16 Gen3, continuous words
        GEN = 3'd3; LANESNUMBER = 5'd16; ramp_data(0); txValid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            if (c >= 1) check_eq("x16_valid", laneValid, 16'hFFFF);
            if (c == 1) begin
                check_eq("x16_lane0", laneData[31:0], 32'h30201000);
                check_eq("x16_lane15", laneData[511:480], 32'h3F2F1F0F);
            end
        end
        txValid = 1'b0;
        repeat (2) run_cycle();

        // x1 Gen1, single word
        GEN = 3'd1; LANESNUMBER = 5'd1; ramp_data(0); txValid = 1'b1;
        vcount = 0;
        run_cycle();
        txValid = 1'b0;
        repeat (66) run_cycle();
        check_eq("x1_slices", 32'(vcount), 32'd64);

        // x4 Gen2, one K byte
        GEN = 3'd2; LANESNUMBER = 5'd4; ramp_data(0); txDataK = 64'h20; txValid = 1'b1;
        run_cycle();
        txValid = 1'b0;
        run_cycle();
        check_eq("x4_lane1", laneData[47:32], 16'h0501);
        check_eq("x4_k", laneDataK, 64'h20);
        repeat (9) run_cycle();
        txDataK = '0;

        // x8 Gen1 back-to-back, valid held high
        GEN = 3'd1; LANESNUMBER = 5'd8; ramp_data(0); txValid = 1'b1;
        naccept = 0; vcount = 0;
        for (int c = 0; c < 30; c++) begin
            run_cycle();
            if (last_acc) begin
                naccept++;
                if (naccept == 1) ramp_data(8'h80);
                else txValid = 1'b0;
            end
        end
        check_eq("b2b_accepts", 32'(naccept), 32'd2);
        check_eq("b2b_slices", 32'(vcount), 32'd16);

        // x2 Gen1, reset during slice 3
        GEN = 3'd1; LANESNUMBER = 5'd2; ramp_data(8'h40); txValid = 1'b1;
        run_cycle();
        txValid = 1'b0;
        repeat (4) run_cycle();
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_ready", txReady, 1'b1);
        check_eq("mid_rst_valid", laneValid, 16'h0);
        check_eq("mid_rst_data", laneData, '0);
        check_eq("mid_rst_k", laneDataK, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        vcount = 0;
        repeat (40) run_cycle();
        check_eq("post_rst_idle", 32'(vcount), 32'd0);

        // Illegal config behaves as x1 Gen1
        GEN = 3'd7; LANESNUMBER = 5'd3; ramp_data(8'h10); txValid = 1'b1;
        vcount = 0;
        run_cycle();
        txValid = 1'b0;
        repeat (66) run_cycle();
        check_eq("bad_cfg_slices", 32'(vcount), 32'd64);

        // Randomized traffic with config changing freely
        for (int c = 0; c < 3000; c++) begin
            txValid     = ($urandom_range(0, 3) != 0);
            GEN         = 3'($urandom_range(0, 7));
            LANESNUMBER = 5'(lanes_tab[$urandom_range(0, 9)]);
            for (int w = 0; w < 16; w++) txData[32*w +: 32] = $urandom;
            txDataK     = {$urandom, $urandom};
            run_cycle();
        end
        txValid = 1'b0;
        repeat (70) run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
